// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads, buffers up to
// two returned words and presents them to decode, honouring stall and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  typedef logic [31:0] instruction_type;

  logic [31:0]     pc;
  logic [1:0]      inflight;
  logic [1:0]      drop;
  logic [1:0]      fifo_count;
  logic            fifo_rd;
  logic            fifo_wr;
  logic [31:0]     fifo_pc   [2];
  instruction_type fifo_word [2];
  logic [31:0]     tag       [2];
  logic            tag_rd;
  logic            tag_wr;

  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;
  logic [2:0]      occupancy;

  always_comb begin
    resp     = imem_rvalid && (inflight != 2'd0);
    if_valid = (fifo_count != 2'd0);
    pop      = if_valid && !stall && !branch_taken;
    push     = resp && (drop == 2'd0) && !branch_taken;
    // A slot freed by this cycle's pop is reusable at once, which is what
    // sustains one instruction per cycle with single-cycle memory.
    occupancy = {1'b0, inflight} + {1'b0, fifo_count} - {2'b00, pop};
    imem_req  = reset_n && !branch_taken && (occupancy < 3'(MAX_INFLIGHT));
    imem_addr = pc;
    accept    = imem_req && imem_ready;
    if_pc          = fifo_pc[fifo_rd];
    if_instruction = fifo_word[fifo_rd];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
      fifo_count <= '0;
      fifo_rd    <= 1'b0;
      fifo_wr    <= 1'b0;
      tag_rd     <= 1'b0;
      tag_wr     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
        tag[i]       <= '0;
      end
    end else begin
      inflight <= inflight + {1'b0, accept} - {1'b0, resp};
      if (accept) begin
        tag[tag_wr] <= pc;
        tag_wr      <= ~tag_wr;
        pc          <= pc + 32'd4;
      end
      if (resp) begin
        tag_rd <= ~tag_rd;
      end
      if (branch_taken) begin
        // Every request still outstanding after this edge belongs to the old path.
        pc         <= branch_target & 32'hFFFF_FFFC;
        fifo_count <= '0;
        fifo_rd    <= 1'b0;
        fifo_wr    <= 1'b0;
        drop       <= inflight - {1'b0, resp};
      end else begin
        if (resp && (drop != 2'd0)) begin
          drop <= drop - 2'd1;
        end
        if (push) begin
          fifo_pc[fifo_wr]   <= tag[tag_rd];
          fifo_word[fifo_wr] <= imem_rdata;
          fifo_wr            <= ~fifo_wr;
        end
        if (pop) begin
          fifo_rd <= ~fifo_rd;
        end
        fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(imem_rvalid && (inflight == 2'd0)));

endmodule
